// File: rtl/tetris_pkg.sv
// Shared tetromino types plus the constants used by the 7-bag piece generator.
package tetris_pkg;

    localparam int unsigned NUM_PIECE_TYPES = 7;
    localparam logic [6:0]  BAG_FULL        = 7'h7F;
    localparam logic [15:0] LFSR_TAPS       = 16'hB400;

    typedef enum logic [2:0] {
        PIECE_I = 3'd0,
        PIECE_O = 3'd1,
        PIECE_T = 3'd2,
        PIECE_S = 3'd3,
        PIECE_Z = 3'd4,
        PIECE_J = 3'd5,
        PIECE_L = 3'd6
    } piece_type_t;

    typedef enum logic [1:0] {
        ROT_0   = 2'd0,
        ROT_90  = 2'd1,
        ROT_180 = 2'd2,
        ROT_270 = 2'd3
    } rotation_t;

    typedef struct packed {
        piece_type_t piece_type;
        logic [3:0]  x;
        logic [4:0]  y;
        rotation_t   rot;
    } active_piece_t;

    typedef enum logic {
        DRAW_IDLE = 1'b0,
        DRAW_FILL = 1'b1
    } draw_state_t;

    function automatic logic [2:0] lowest_set(input logic [6:0] mask);
        logic [2:0] idx;
        logic       found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_PIECE_TYPES; i++) begin
            if (mask[i] && !found) begin
                idx   = 3'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/piece_bag_generator_lfsr16.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) with synchronous reset and load.
module lfsr16
    import tetris_pkg::*;
#(
    parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        step,
    output logic [15:0] value
);

    logic [15:0] value_q;
    logic [15:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_value;
        end else if (step) begin
            value_d = {1'b0, value_q[15:1]} ^ (value_q[0] ? LFSR_TAPS : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= DEFAULT_SEED;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/piece_bag_generator.sv
// 7-bag tetromino feeder: LFSR-driven draws into a small FIFO with head + preview.
module piece_bag_generator
    import tetris_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_SEED = 16'hACE1,
    parameter logic [3:0]  SPAWN_X      = 4'd4,
    parameter int unsigned MAX_REJECT   = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          seed_load,
    input  logic [15:0]   seed,
    input  logic          advance,
    output active_piece_t new_piece,
    output logic          piece_valid,
    output piece_type_t   preview_types [QUEUE_DEPTH-1],
    output logic          underflow
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned REJ_W = $clog2(MAX_REJECT + 1);

    draw_state_t       state_q, state_d;
    logic [6:0]        mask_q, mask_d;
    logic [REJ_W-1:0]  rej_q, rej_d;
    logic [PTR_W-1:0]  rd_q, rd_d;
    logic [PTR_W-1:0]  wr_q, wr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              underflow_q, underflow_d;
    piece_type_t       mem_q [QUEUE_DEPTH];
    piece_type_t       mem_d [QUEUE_DEPTH];

    logic [15:0]       lfsr_value;
    logic [15:0]       seed_eff;
    logic              lfsr_unused;
    logic [2:0]        cand;
    logic [2:0]        pick;
    logic [6:0]        mask_after;
    logic              cand_ok;
    logic              force_pick;
    logic              push;
    logic              pop;
    int unsigned       slot;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign seed_eff = (seed == '0) ? DEFAULT_SEED : seed;

    lfsr16 #(
        .DEFAULT_SEED (DEFAULT_SEED)
    ) u_lfsr (
        .clk        (clk),
        .reset      (reset),
        .load       (seed_load),
        .load_value (seed_eff),
        .step       (1'b1),
        .value      (lfsr_value)
    );

    // Only the low three LFSR bits feed the draw.
    assign lfsr_unused = ^lfsr_value[15:3];
    assign cand        = lfsr_value[2:0];
    assign cand_ok     = (cand != 3'd7) && mask_q[cand];
    assign force_pick  = (rej_q == REJ_W'(MAX_REJECT - 1));

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        rej_d       = rej_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        count_d     = count_q;
        underflow_d = underflow_q;
        mem_d       = mem_q;
        push        = 1'b0;
        pop         = 1'b0;
        pick        = cand;
        mask_after  = mask_q;

        if (seed_load) begin
            state_d     = DRAW_FILL;
            mask_d      = BAG_FULL;
            rej_d       = '0;
            rd_d        = '0;
            wr_d        = '0;
            count_d     = '0;
            underflow_d = 1'b0;
        end else begin
            if (state_q == DRAW_FILL) begin
                if (cand_ok || force_pick) begin
                    push       = 1'b1;
                    pick       = cand_ok ? cand : lowest_set(mask_q);
                    rej_d      = '0;
                    mask_after = mask_q & ~(7'b1 << pick);
                    mask_d     = (mask_after == '0) ? BAG_FULL : mask_after;
                end else begin
                    rej_d = rej_q + 1'b1;
                end
            end

            if (advance) begin
                if (count_q != '0) begin
                    pop = 1'b1;
                end else begin
                    underflow_d = 1'b1;
                end
            end

            if (push) begin
                mem_d[wr_q] = piece_type_t'(pick);
                wr_d        = next_ptr(wr_q);
            end
            if (pop) begin
                rd_d = next_ptr(rd_q);
            end

            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase

            state_d = (count_d < CNT_W'(QUEUE_DEPTH)) ? DRAW_FILL : DRAW_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= DRAW_FILL;
            mask_q      <= BAG_FULL;
            rej_q       <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            rej_q       <= rej_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage needs no reset: count_q gates every read below.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        piece_valid          = (count_q != '0);
        new_piece            = '0;
        new_piece.piece_type = piece_valid ? mem_q[rd_q] : PIECE_I;
        new_piece.x          = SPAWN_X;
        new_piece.y          = '0;
        new_piece.rot        = ROT_0;
        slot                 = 0;
        for (int unsigned i = 0; i < QUEUE_DEPTH - 1; i++) begin
            slot = int'(rd_q) + i + 1;
            if (slot >= QUEUE_DEPTH) begin
                slot = slot - QUEUE_DEPTH;
            end
            preview_types[i] = (CNT_W'(i + 1) < count_q) ? mem_q[slot[PTR_W-1:0]] : PIECE_I;
        end
        underflow = underflow_q;
    end

endmodule

// File: tb/tb_piece_bag_generator.sv
// Scoreboard bench for piece_bag_generator: cycle model feeds an expected queue, monitor compares.
module tb_piece_bag_generator;
    import tetris_pkg::*;

    localparam int DEPTH = 4;
    localparam int MAXR  = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          seed_load = 1'b0;
    logic [15:0]   seed = 16'h0000;
    logic          advance = 1'b0;
    active_piece_t new_piece;
    logic          piece_valid;
    piece_type_t   preview_types [DEPTH-1];
    logic          underflow;

    piece_bag_generator #(
        .QUEUE_DEPTH  (DEPTH),
        .DEFAULT_SEED (16'hACE1),
        .SPAWN_X      (4'd4),
        .MAX_REJECT   (MAXR)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .seed_load     (seed_load),
        .seed          (seed),
        .advance       (advance),
        .new_piece     (new_piece),
        .piece_valid   (piece_valid),
        .preview_types (preview_types),
        .underflow     (underflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model of the 7-bag generator, advanced on every rising edge.
    logic [15:0] m_lfsr;
    logic [6:0]  m_mask;
    int          m_rej;
    int          m_count;
    bit          m_uf;
    int          exp_q[$];
    int          iss_q[$];
    bit          mon_en = 1'b0;
    int          mp;
    int          mpre;

    function automatic logic [15:0] m_step(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) begin
            r[15] = ~r[15];
            r[13] = ~r[13];
            r[12] = ~r[12];
            r[10] = ~r[10];
        end
        return r;
    endfunction

    function automatic int m_next_push();
        int c;
        c = int'(m_lfsr[2:0]);
        if (m_count >= DEPTH) return -1;
        if (c != 7 && m_mask[c]) return c;
        if (m_rej == MAXR - 1) begin
            for (int t = 0; t < 7; t++) begin
                if (m_mask[t]) return t;
            end
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (reset || seed_load) begin
            m_lfsr  = (reset || seed == 16'h0000) ? 16'hACE1 : seed;
            m_mask  = 7'h7F;
            m_rej   = 0;
            m_count = 0;
            m_uf    = 1'b0;
            exp_q.delete();
        end else begin
            mpre = m_count;
            mp   = m_next_push();
            if (mpre < DEPTH) begin
                if (mp >= 0) begin
                    exp_q.push_back(mp);
                    m_mask[mp] = 1'b0;
                    if (m_mask == 7'h00) m_mask = 7'h7F;
                    m_rej = 0;
                    m_count++;
                end else begin
                    m_rej++;
                end
            end
            if (advance) begin
                if (mpre > 0) m_count--;
                else m_uf = 1'b1;
            end
            m_lfsr = m_step(m_lfsr);
        end
    end

    // Monitor: compares presented outputs against the expected queue, pops on consumption.
    always @(negedge clk) begin
        int eh;
        int ep;
        #1;
        if (mon_en) begin
            eh = (exp_q.size() != 0) ? exp_q[0] : 0;
            chk("valid", piece_valid, (exp_q.size() != 0) ? 1 : 0);
            chk("head", new_piece, eh * 2048 + 4 * 128);
            for (int i = 0; i < DEPTH - 1; i++) begin
                ep = (i + 1 < exp_q.size()) ? exp_q[i + 1] : 0;
                chk($sformatf("preview%0d", i), preview_types[i], ep);
            end
            chk("underflow", underflow, m_uf);
            if (advance && !reset && !seed_load && exp_q.size() != 0) begin
                iss_q.push_back(int'(new_piece.piece_type));
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_seed(input logic [15:0] s, input logic with_adv);
        seed      = s;
        seed_load = 1'b1;
        advance   = with_adv;
        @(negedge clk);
        seed_load = 1'b0;
        advance   = 1'b0;
    endtask

    task automatic do_run();
        iss_q.delete();
        cyc(6);
        repeat (7) begin
            advance = 1'b1;
            @(negedge clk);
            advance = 1'b0;
            @(negedge clk);
        end
    endtask

    int seq_a[$];
    int seq_b[$];
    int seq_c[$];
    int seq_d[$];
    int seq_e[$];
    int hand_first[4] = '{1, 0, 4, 6};

    task automatic cmp_seq(input string name, input int got[$], input int want[$]);
        chk({name, "_len"}, got.size(), 7);
        for (int i = 0; i < 7; i++) begin
            chk(name, (i < got.size()) ? got[i] : -1, (i < want.size()) ? want[i] : -2);
        end
    endtask

    initial begin
        int cnt [7];
        int old1;
        int newt;
        bit found;

        repeat (3) @(negedge clk);
        mon_en = 1'b1;

        // Release reset with an advance against the empty FIFO.
        reset   = 1'b0;
        advance = 1'b1;
        @(negedge clk);
        advance = 1'b0;
        #1;
        chk("first_valid", piece_valid, 1);
        chk("uf_set", underflow, 1);
        cyc(4);
        #1;
        chk("full_head", new_piece, 1 * 2048 + 4 * 128);
        chk("full_p0", preview_types[0], 0);
        chk("full_p1", preview_types[1], 4);
        chk("full_p2", preview_types[2], 6);

        // Fourteen spaced pulls: each 7-run is one full bag.
        iss_q.delete();
        repeat (14) begin
            advance = 1'b1;
            @(negedge clk);
            advance = 1'b0;
            cyc(3);
        end
        chk("bag_len", iss_q.size(), 14);
        for (int g = 0; g < 2; g++) begin
            for (int t = 0; t < 7; t++) cnt[t] = 0;
            for (int k = 0; k < 7; k++) begin
                if (g * 7 + k < iss_q.size() && iss_q[g * 7 + k] < 7) cnt[iss_q[g * 7 + k]]++;
            end
            for (int t = 0; t < 7; t++) chk($sformatf("bag%0d_type%0d", g, t), cnt[t], 1);
        end
        #1;
        chk("uf_sticky", underflow, 1);

        // Reseeding: default, zero seed, and a repeated explicit seed.
        pulse_reset();
        do_run();
        seq_a = iss_q;
        pulse_seed(16'h0000, 1'b0);
        #1;
        chk("uf_cleared", underflow, 0);
        do_run();
        seq_b = iss_q;
        cmp_seq("seed0_seq", seq_b, seq_a);
        for (int i = 0; i < 4; i++) begin
            chk("hand_first", (i < seq_b.size()) ? seq_b[i] : -1, hand_first[i]);
        end
        pulse_seed(16'h1234, 1'b0);
        do_run();
        seq_c = iss_q;
        pulse_seed(16'h1234, 1'b1);
        do_run();
        seq_d = iss_q;
        cmp_seq("seed1234_seq", seq_d, seq_c);

        // Pop coinciding with an accepted refill draw.
        pulse_reset();
        cyc(6);
        advance = 1'b1;
        @(negedge clk);
        advance = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (m_next_push() >= 0 && exp_q.size() >= 2) begin
                found   = 1'b1;
                old1    = exp_q[1];
                newt    = m_next_push();
                advance = 1'b1;
                @(negedge clk);
                advance = 1'b0;
                #1;
                chk("t5_head", new_piece.piece_type, old1);
                chk("t5_tail", preview_types[1], newt);
            end else begin
                @(negedge clk);
            end
        end
        chk("t5_found", found, 1);
        cyc(12);

        // Reset in the middle of filling.
        pulse_reset();
        cyc(2);
        #1;
        chk("mid_head", new_piece, 1 * 2048 + 4 * 128);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_valid", piece_valid, 0);
        chk("rst_head", new_piece, 4 * 128);
        for (int i = 0; i < DEPTH - 1; i++) chk("rst_preview", preview_types[i], 0);
        do_run();
        seq_e = iss_q;
        cmp_seq("post_reset_seq", seq_e, seq_a);

        cyc(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
